// File: rtl/elm_layer_sched.sv
// elm_layer_sched: sequencer for one ELM hidden layer. It loads weights and
// biases into the neurons, broadcasts one input vector, then collects and
// drains the results.
// Ports: clk, rst (async, active-high); load_start; cfg_* config stream;
//   x_* input stream; n_rst, weight*, n_bias_valid, biasValue, config_*,
//   myinput* drive the neuron array; n_outvalid/n_out come back from it;
//   y_* result stream; loaded/busy/err_timeout status.
module elm_layer_sched #(
  parameter int DATA_W     = 16,
  parameter int OUT_W      = 16,
  parameter int NUM_NEURON = 8,
  parameter int NUM_WEIGHT = 128,
  parameter int LAYER_NO   = 1,
  parameter int WAIT_MAX   = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_start,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [DATA_W-1:0]             cfg_data,
  input  logic                          x_valid,
  output logic                          x_ready,
  input  logic [DATA_W-1:0]             x_data,
  output logic                          n_rst,
  output logic                          weightValid,
  output logic [DATA_W-1:0]             weightValue,
  output logic [NUM_NEURON-1:0]         n_bias_valid,
  output logic [DATA_W-1:0]             biasValue,
  output logic [2*DATA_W:0]             config_layer_num,
  output logic [2*DATA_W:0]             config_neuron_num,
  output logic                          myinputValid,
  output logic [DATA_W-1:0]             myinput,
  input  logic [NUM_NEURON-1:0]         n_outvalid,
  input  logic [NUM_NEURON*OUT_W-1:0]   n_out,
  output logic                          y_valid,
  input  logic                          y_ready,
  output logic [OUT_W-1:0]              y_data,
  output logic [$clog2(NUM_NEURON)-1:0] y_idx,
  output logic                          y_last,
  output logic                          loaded,
  output logic                          busy,
  output logic                          err_timeout
);

  localparam int KW   = $clog2(NUM_NEURON);
  localparam int CW_A = $clog2(NUM_WEIGHT);
  localparam int CW_B = $clog2(WAIT_MAX);
  localparam int CW_M = (CW_A > CW_B) ? CW_A : CW_B;
  localparam int CW   = (CW_M > 0) ? CW_M : 1;
  localparam int SW   = 2*DATA_W+1;

  localparam logic [KW-1:0] K_LAST = KW'(NUM_NEURON-1);
  localparam logic [CW-1:0] W_LAST = CW'(NUM_WEIGHT-1);
  localparam logic [CW-1:0] T_LAST = CW'(WAIT_MAX-1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD_W,
    S_LOAD_B,
    S_READY,
    S_STREAM,
    S_WAIT,
    S_DRAIN
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [KW-1:0]         k_q, k_d;
  logic [NUM_NEURON-1:0] done_q, done_d;
  logic [OUT_W-1:0]      cap_q [NUM_NEURON];
  logic [OUT_W-1:0]      cap_d [NUM_NEURON];

  logic                  n_rst_q, n_rst_d;
  logic                  cfg_ready_q, cfg_ready_d;
  logic                  x_ready_q, x_ready_d;
  logic                  wv_q, wv_d;
  logic [DATA_W-1:0]     wval_q, wval_d;
  logic [NUM_NEURON-1:0] bv_q, bv_d;
  logic [DATA_W-1:0]     bval_q, bval_d;
  logic [SW-1:0]         lay_q, lay_d;
  logic [SW-1:0]         nsel_q, nsel_d;
  logic                  iv_q, iv_d;
  logic [DATA_W-1:0]     ival_q, ival_d;
  logic                  yv_q, yv_d;
  logic [OUT_W-1:0]      yd_q, yd_d;
  logic [KW-1:0]         yi_q, yi_d;
  logic                  yl_q, yl_d;
  logic                  loaded_q, loaded_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;

  logic                  cfg_hs;
  logic                  x_hs;
  logic                  y_hs;
  logic                  all_done;
  logic [KW-1:0]         y_nxt;
  logic [NUM_NEURON-1:0] one_hot0;

  // Handshakes use the registered ready, so a word is only taken in the
  // state that advertised readiness.
  assign cfg_hs   = cfg_valid & cfg_ready_q;
  assign x_hs     = x_valid & x_ready_q;
  assign y_hs     = yv_q & y_ready;
  // A neuron reporting this cycle counts as done for the exit decision.
  assign all_done = &(done_q | n_outvalid);
  assign y_nxt    = yi_q + KW'(1);
  assign one_hot0 = {{(NUM_NEURON-1){1'b0}}, 1'b1};

  // State register and all datapath/output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      k_q         <= '0;
      done_q      <= '0;
      for (int i = 0; i < NUM_NEURON; i++) cap_q[i] <= '0;
      n_rst_q     <= 1'b1;
      cfg_ready_q <= 1'b0;
      x_ready_q   <= 1'b0;
      wv_q        <= 1'b0;
      wval_q      <= '0;
      bv_q        <= '0;
      bval_q      <= '0;
      lay_q       <= '0;
      nsel_q      <= '0;
      iv_q        <= 1'b0;
      ival_q      <= '0;
      yv_q        <= 1'b0;
      yd_q        <= '0;
      yi_q        <= '0;
      yl_q        <= 1'b0;
      loaded_q    <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      done_q      <= done_d;
      cap_q       <= cap_d;
      n_rst_q     <= n_rst_d;
      cfg_ready_q <= cfg_ready_d;
      x_ready_q   <= x_ready_d;
      wv_q        <= wv_d;
      wval_q      <= wval_d;
      bv_q        <= bv_d;
      bval_q      <= bval_d;
      lay_q       <= lay_d;
      nsel_q      <= nsel_d;
      iv_q        <= iv_d;
      ival_q      <= ival_d;
      yv_q        <= yv_d;
      yd_q        <= yd_d;
      yi_q        <= yi_d;
      yl_q        <= yl_d;
      loaded_q    <= loaded_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (load_start) state_d = S_CLR;
      end
      S_READY: begin
        // A reload request wins over a waiting input vector.
        if (load_start)   state_d = S_CLR;
        else if (x_valid) state_d = S_STREAM;
      end
      S_CLR: begin
        state_d = S_LOAD_W;
      end
      S_LOAD_W: begin
        if (cfg_hs && cnt_q == W_LAST) state_d = S_LOAD_B;
      end
      S_LOAD_B: begin
        if (cfg_hs) state_d = (k_q == K_LAST) ? S_READY : S_LOAD_W;
      end
      S_STREAM: begin
        if (x_hs && cnt_q == W_LAST) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (all_done || cnt_q == T_LAST) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (y_hs && yl_q) state_d = S_READY;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    cnt_d    = cnt_q;
    k_d      = k_q;
    done_d   = done_q;
    cap_d    = cap_q;
    wv_d     = 1'b0;
    wval_d   = wval_q;
    bv_d     = '0;
    bval_d   = bval_q;
    lay_d    = lay_q;
    nsel_d   = nsel_q;
    iv_d     = 1'b0;
    ival_d   = ival_q;
    yv_d     = yv_q;
    yd_d     = yd_q;
    yi_d     = yi_q;
    yl_d     = yl_q;
    loaded_d = loaded_q;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE, S_READY: begin
        cnt_d = '0;
        if (state_d == S_CLR) begin
          loaded_d = 1'b0;
          err_d    = 1'b0;
          k_d      = '0;
        end
      end
      S_CLR: begin
        cnt_d = '0;
      end
      S_LOAD_W: begin
        if (cfg_hs) begin
          wv_d   = 1'b1;
          wval_d = cfg_data;
          lay_d  = SW'(LAYER_NO);
          nsel_d = SW'(k_q);
          cnt_d  = (cnt_q == W_LAST) ? '0 : cnt_q + CW'(1);
        end
      end
      S_LOAD_B: begin
        if (cfg_hs) begin
          bv_d   = one_hot0 << k_q;
          bval_d = cfg_data;
          lay_d  = SW'(LAYER_NO);
          nsel_d = SW'(k_q);
          cnt_d  = '0;
          if (k_q == K_LAST) loaded_d = 1'b1;
          else               k_d      = k_q + KW'(1);
        end
      end
      S_STREAM: begin
        if (x_hs) begin
          iv_d   = 1'b1;
          ival_d = x_data;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == W_LAST) begin
            // Fresh capture set: anything not reported drains as zero.
            cnt_d  = '0;
            done_d = '0;
            for (int i = 0; i < NUM_NEURON; i++) cap_d[i] = '0;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        for (int i = 0; i < NUM_NEURON; i++) begin
          if (n_outvalid[i]) begin
            cap_d[i]  = n_out[i*OUT_W +: OUT_W];
            done_d[i] = 1'b1;
          end
        end
        if (state_d == S_DRAIN) begin
          if (!all_done) err_d = 1'b1;
          yv_d = 1'b1;
          yd_d = cap_d[0];
          yi_d = '0;
          yl_d = 1'b0;
        end
      end
      S_DRAIN: begin
        if (y_hs) begin
          if (yl_q) begin
            yv_d   = 1'b0;
            yl_d   = 1'b0;
            done_d = '0;
          end else begin
            yi_d = y_nxt;
            yd_d = cap_q[y_nxt];
            yl_d = (y_nxt == K_LAST);
          end
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
    n_rst_d     = (state_d == S_CLR);
    cfg_ready_d = (state_d == S_LOAD_W) || (state_d == S_LOAD_B);
    x_ready_d   = (state_d == S_STREAM);
    busy_d      = !((state_d == S_IDLE) || (state_d == S_READY));
  end

  assign n_rst             = n_rst_q;
  assign cfg_ready         = cfg_ready_q;
  assign x_ready           = x_ready_q;
  assign weightValid       = wv_q;
  assign weightValue       = wval_q;
  assign n_bias_valid      = bv_q;
  assign biasValue         = bval_q;
  assign config_layer_num  = lay_q;
  assign config_neuron_num = nsel_q;
  assign myinputValid      = iv_q;
  assign myinput           = ival_q;
  assign y_valid           = yv_q;
  assign y_data            = yd_q;
  assign y_idx             = yi_q;
  assign y_last            = yl_q;
  assign loaded            = loaded_q;
  assign busy              = busy_q;
  assign err_timeout       = err_q;

endmodule

// File: tb/tb_elm_layer_sched.sv
// tb_elm_layer_sched: directed bench for elm_layer_sched with a
// word-stream model for load/inference and a result scoreboard.
module tb_elm_layer_sched;

  localparam int NN    = 8;
  localparam int NW    = 128;
  localparam int DW    = 16;
  localparam int OW    = 16;
  localparam int WM    = 64;
  localparam int TOTAL = NN*(NW+1);

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [DW-1:0] cfg_data;
  logic          x_valid;
  logic          x_ready;
  logic [DW-1:0] x_data;
  logic          n_rst;
  logic          weightValid;
  logic [DW-1:0] weightValue;
  logic [NN-1:0] n_bias_valid;
  logic [DW-1:0] biasValue;
  logic [2*DW:0] config_layer_num;
  logic [2*DW:0] config_neuron_num;
  logic          myinputValid;
  logic [DW-1:0] myinput;
  logic [NN-1:0] n_outvalid;
  logic [NN*OW-1:0] n_out;
  logic          y_valid;
  logic          y_ready;
  logic [OW-1:0] y_data;
  logic [2:0]    y_idx;
  logic          y_last;
  logic          loaded;
  logic          busy;
  logic          err_timeout;

  elm_layer_sched #(
    .DATA_W(DW), .OUT_W(OW), .NUM_NEURON(NN),
    .NUM_WEIGHT(NW), .LAYER_NO(1), .WAIT_MAX(WM)
  ) dut (
    .clk(clk), .rst(rst), .load_start(load_start),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .n_rst(n_rst), .weightValid(weightValid), .weightValue(weightValue),
    .n_bias_valid(n_bias_valid), .biasValue(biasValue),
    .config_layer_num(config_layer_num),
    .config_neuron_num(config_neuron_num),
    .myinputValid(myinputValid), .myinput(myinput),
    .n_outvalid(n_outvalid), .n_out(n_out),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data),
    .y_idx(y_idx), .y_last(y_last),
    .loaded(loaded), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model / scoreboard state
  logic [OW-1:0] exp_y [NN];
  logic [OW-1:0] got_y [NN];
  int widx = 0;
  int in_pulses = 0;
  int ytotal = 0;
  int yi = 0;
  int stall_cnt = 0;
  int nrst_pulses = 0;
  int last_x_cyc = 0;
  int err_cyc = 0;
  int yrise_cyc = 0;
  int nk, pos;
  logic p_cfg = 1'b0;
  logic p_x = 1'b0;
  logic [DW-1:0] p_xd = '0;
  logic p_err = 1'b0;
  logic p_yv = 1'b0;
  logic p_nrst = 1'b1;
  logic ystall = 1'b0;
  logic [OW-1:0] sy_d;
  logic [2:0] sy_i;
  logic sy_l;

  // Compare process: the strobe for a word accepted in one cycle must
  // appear in the next cycle, with values following the word order.
  always @(negedge clk) begin
    if (rst) begin
      p_cfg = 1'b0; p_x = 1'b0; widx = 0; yi = 0;
      ystall = 1'b0; p_nrst = 1'b1; p_yv = 1'b0; p_err = 1'b0;
    end else begin
      if (n_rst) widx = 0;
      if (p_cfg) begin
        nk = widx / (NW+1);
        pos = widx % (NW+1);
        if (pos < NW) begin
          chk("w_valid", weightValid, 1);
          chk("w_value", weightValue, 64'(widx));
          chk("w_neuron", config_neuron_num, 64'(nk));
          chk("w_layer", config_layer_num, 1);
          chk("w_nobias", n_bias_valid, 0);
        end else begin
          chk("b_noweight", weightValid, 0);
          chk("b_sel", n_bias_valid, 64'(1) << nk);
          chk("b_value", biasValue, 64'(widx));
        end
        chk("loaded_at_word", loaded, (widx == TOTAL-1));
        widx++;
      end else begin
        chk("w_idle", weightValid, 0);
        chk("b_idle", n_bias_valid, 0);
      end
      p_cfg = cfg_valid && cfg_ready;

      if (p_x) begin
        chk("in_valid", myinputValid, 1);
        chk("in_value", myinput, p_xd);
        in_pulses++;
      end else begin
        chk("in_idle", myinputValid, 0);
      end
      p_x = x_valid && x_ready;
      p_xd = x_data;
      if (p_x) last_x_cyc = cyc;

      if (err_timeout && !p_err) err_cyc = cyc;
      p_err = err_timeout;
      if (y_valid && !p_yv) yrise_cyc = cyc;
      p_yv = y_valid;
      if (n_rst && !p_nrst) nrst_pulses++;
      p_nrst = n_rst;

      if (y_valid) begin
        if (ystall) begin
          chk("y_hold_data", y_data, sy_d);
          chk("y_hold_idx", y_idx, sy_i);
          chk("y_hold_last", y_last, sy_l);
        end
        chk("y_idx", y_idx, 64'(yi));
        chk("y_data", y_data, exp_y[yi]);
        chk("y_last", y_last, (yi == NN-1));
        got_y[yi] = y_data;
        if (y_ready) begin
          ytotal++;
          yi = (yi == NN-1) ? 0 : yi + 1;
          ystall = 1'b0;
        end else begin
          stall_cnt++;
          ystall = 1'b1;
          sy_d = y_data; sy_i = y_idx; sy_l = y_last;
        end
      end else begin
        ystall = 1'b0;
      end
    end
  end

  // Result-side ready: always high, or the 1-0-0-1 pattern.
  logic bp_mode = 1'b0;
  logic bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  int ph = 0;
  initial begin
    y_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bp_mode) begin
        y_ready = bp_pat[ph];
        ph = (ph + 1) % 4;
      end else begin
        y_ready = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic load_pulse();
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    @(negedge clk);
    chk("clr_nrst", n_rst, 1);
    chk("clr_cfg_ready", cfg_ready, 0);
    chk("clr_loaded", loaded, 0);
    @(negedge clk);
    chk("loadw_cfg_ready", cfg_ready, 1);
    chk("loadw_nrst", n_rst, 0);
    @(posedge clk); #1;
  endtask

  task automatic send_cfg(input int first, input int last, input bit gaps);
    logic acc;
    int n;
    for (int j = first; j <= last; j++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        cfg_valid = 1'b0;
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      cfg_valid = 1'b1;
      cfg_data = j[DW-1:0];
      acc = 1'b0;
      n = 0;
      while (!acc && n < 50) begin
        @(negedge clk); acc = cfg_ready;
        @(posedge clk); #1;
        n++;
      end
      if (!acc) chk("cfg_accept_timeout", 0, 1);
    end
    cfg_valid = 1'b0;
  endtask

  task automatic send_x(input int cnt);
    logic acc;
    int n;
    for (int j = 0; j < cnt; j++) begin
      x_valid = 1'b1;
      x_data = 16'h5000 + j[DW-1:0];
      acc = 1'b0;
      n = 0;
      while (!acc && n < 50) begin
        @(negedge clk); acc = x_ready;
        @(posedge clk); #1;
        n++;
      end
      if (!acc) chk("x_accept_timeout", 0, 1);
    end
    x_valid = 1'b0;
  endtask

  int ov_cyc = 0;

  task automatic run_vector(input logic [NN-1:0] mask,
                            input logic [OW-1:0] base, input bit bp);
    int ib, yb, n;
    bp_mode = bp;
    for (int k = 0; k < NN; k++) begin
      n_out[k*OW +: OW] = base + OW'(k);
      exp_y[k] = mask[k] ? base + OW'(k) : '0;
    end
    ib = in_pulses;
    yb = ytotal;
    send_x(NW);
    n = 0;
    while (in_pulses - ib < NW && n < 20) begin @(negedge clk); n++; end
    chk("in_pulses_seen", in_pulses - ib, NW);
    repeat (6) @(posedge clk);
    #1;
    n_outvalid = mask;
    ov_cyc = cyc;
    @(posedge clk); #1;
    n_outvalid = '0;
    n = 0;
    while (ytotal - yb < NN && n < 300) begin @(negedge clk); n++; end
    chk("y_count", ytotal - yb, NN);
    repeat (3) @(negedge clk);
    chk("y_no_extra", ytotal - yb, NN);
    chk("in_exact", in_pulses - ib, NW);
    chk("back_ready_busy", busy, 0);
    chk("back_ready_loaded", loaded, 1);
    chk("back_ready_yv", y_valid, 0);
    bp_mode = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; load_start = 1'b0;
    cfg_valid = 1'b0; cfg_data = '0;
    x_valid = 1'b0; x_data = '0;
    n_outvalid = '0; n_out = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_nrst", n_rst, 1);
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_x_ready", x_ready, 0);
    chk("rst_wv", weightValid, 0);
    chk("rst_bv", n_bias_valid, 0);
    chk("rst_iv", myinputValid, 0);
    chk("rst_yv", y_valid, 0);
    chk("rst_loaded", loaded, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_layer", config_layer_num, 0);
    chk("rst_neuron", config_neuron_num, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("nrst_hold", n_rst, 1);
    @(negedge clk);
    chk("nrst_release", n_rst, 0);
    chk("idle_cfg_ready", cfg_ready, 0);
    @(posedge clk); #1;

    // Reset in the middle of a load
    load_pulse();
    send_cfg(0, 500, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_nrst", n_rst, 1);
    chk("mid_rst_cfg_ready", cfg_ready, 0);
    chk("mid_rst_wv", weightValid, 0);
    chk("mid_rst_bv", n_bias_valid, 0);
    chk("mid_rst_loaded", loaded, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_neuron", config_neuron_num, 0);
    chk("mid_rst_layer", config_layer_num, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_cfg_ready", cfg_ready, 0);
      chk("post_rst_loaded", loaded, 0);
    end
    @(posedge clk); #1;

    // Full load with gaps
    load_pulse();
    send_cfg(0, TOTAL-1, 1'b1);
    repeat (3) @(negedge clk);
    chk("load_done_loaded", loaded, 1);
    chk("load_done_cfg_ready", cfg_ready, 0);
    chk("load_done_busy", busy, 0);
    chk("load_words", widx, TOTAL);
    @(posedge clk); #1;

    // Full-rate inference
    run_vector(8'hFF, 16'h0100, 1'b0);
    chk("lit_y0", got_y[0], 16'h0100);
    chk("lit_y7", got_y[7], 16'h0107);
    chk("y_latency", yrise_cyc - ov_cyc, 1);
    chk("no_timeout", err_timeout, 0);

    // Backpressure
    stall_cnt = 0;
    run_vector(8'hFF, 16'h0300, 1'b1);
    chk("stalls_seen", (stall_cnt > 0), 1);
    chk("lit_bp_y5", got_y[5], 16'h0305);

    // Timeout: neuron 3 silent
    run_vector(8'hF7, 16'h0200, 1'b0);
    chk("timeout_flag", err_timeout, 1);
    chk("timeout_delay", err_cyc - last_x_cyc, 1 + WM);
    chk("timeout_y_start", yrise_cyc, err_cyc);
    chk("lit_to_y3", got_y[3], 16'h0000);
    chk("lit_to_y4", got_y[4], 16'h0204);

    // load_start and x_valid together in READY
    begin
      int np, ib;
      np = nrst_pulses;
      ib = in_pulses;
      load_start = 1'b1;
      x_valid = 1'b1;
      x_data = 16'hABCD;
      @(posedge clk); #1;
      load_start = 1'b0;
      @(negedge clk);
      chk("sim_nrst", n_rst, 1);
      chk("sim_loaded", loaded, 0);
      chk("sim_x_ready", x_ready, 0);
      chk("sim_err_clr", err_timeout, 0);
      @(negedge clk);
      chk("sim_cfg_ready", cfg_ready, 1);
      chk("sim_nrst_off", n_rst, 0);
      repeat (4) begin
        @(negedge clk);
        chk("sim_x_ready_hold", x_ready, 0);
      end
      chk("sim_no_input", in_pulses - ib, 0);
      chk("sim_one_nrst", nrst_pulses - np, 1);
      chk("sim_busy", busy, 1);
      x_valid = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
